// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame parser and framer: state encodings,
// error codes, SOF default and the inter-byte timeout helper.
package uart_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LEN     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_CHECK   = 2'd3;

    typedef logic [1:0] errCode_t;

    localparam errCode_t ERR_NONE    = 2'd0;
    localparam errCode_t ERR_LEN     = 2'd1;
    localparam errCode_t ERR_CHK     = 2'd2;
    localparam errCode_t ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] SOF_DEFAULT = 8'h55;

    // One UART character is 10 bit times (start + 8 data + stop).
    function automatic int unsigned timeoutCycles(input int unsigned sysClock,
                                                  input int unsigned baudRate,
                                                  input int unsigned nBytes);
        return sysClock / baudRate * 10 * nBytes;
    endfunction

endpackage

// File: rtl/uart_rx_frame_parser_if.sv
// Byte-stream input and payload/frame-result outputs of the frame parser.
interface uart_rx_frame_parser_if;
    import uart_pkg::*;

    logic [7:0] i_Byte;
    logic       i_ByteValid;
    logic [7:0] o_PayloadByte;
    logic       o_PayloadValid;
    logic       o_PayloadLast;
    logic       o_FrameOk;
    logic       o_FrameErr;
    errCode_t   o_ErrCode;
    logic       o_Busy;

    modport slave (
        input  i_Byte, i_ByteValid,
        output o_PayloadByte, o_PayloadValid, o_PayloadLast,
        output o_FrameOk, o_FrameErr, o_ErrCode, o_Busy
    );

    modport master (
        output i_Byte, i_ByteValid,
        input  o_PayloadByte, o_PayloadValid, o_PayloadLast,
        input  o_FrameOk, o_FrameErr, o_ErrCode, o_Busy
    );

endinterface

// File: rtl/uart_frame_timer.sv
// Inter-byte gap counter: counts while enabled, clears on i_Clear or when
// disabled, and flags o_Expire while the count sits at LIMIT.
module uart_frame_timer #(
    parameter int unsigned LIMIT = 1736
) (
    input  logic i_SysClock,
    input  logic i_Reset,
    input  logic i_Clear,
    input  logic i_Enable,
    output logic o_Expire
);

    localparam int unsigned W = $clog2(LIMIT) + 1;
    localparam logic [W-1:0] LimitW = W'(LIMIT);

    logic [W-1:0] countQ, countD;

    // Saturate at the limit so a stalled owner cannot wrap the counter.
    always_comb begin
        countD = countQ;
        if (i_Clear || !i_Enable) begin
            countD = '0;
        end else if (countQ != LimitW) begin
            countD = countQ + W'(1);
        end
    end

    always_ff @(posedge i_SysClock) begin
        if (i_Reset) begin
            countQ <= '0;
        end else begin
            countQ <= countD;
        end
    end

    assign o_Expire = i_Enable && (countQ == LimitW);

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Recovers SOF, LEN, PAYLOAD[LEN], CHK frames from the received byte stream,
// forwarding payload bytes and ending each frame with an ok or error pulse.
module uart_rx_frame_parser
    import uart_pkg::*;
#(
    parameter int unsigned SYS_CLOCK     = 50000000,
    parameter int unsigned UART_BAUDRATE = 115200,
    parameter logic [7:0]  SOF_BYTE      = SOF_DEFAULT,
    parameter int unsigned MAX_LEN       = 64,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input  logic                   i_SysClock,
    input  logic                   i_Reset,
    uart_rx_frame_parser_if.slave  bus
);

    localparam int unsigned TimeoutLimit = timeoutCycles(SYS_CLOCK, UART_BAUDRATE, TIMEOUT_BYTES);
    localparam logic [7:0]  MaxLen8      = 8'(MAX_LEN);

    logic [1:0] stateQ, stateD;
    logic [7:0] lenQ, lenD;
    logic [7:0] chkQ, chkD;
    logic [7:0] cntQ, cntD;
    logic [7:0] payByteQ, payByteD;
    logic       payValidQ, payValidD;
    logic       payLastQ, payLastD;
    logic       okQ, okD;
    logic       errQ, errD;
    errCode_t   errCodeQ, errCodeD;

    logic timerEn;
    logic expire;

    assign timerEn = (stateQ != ST_IDLE);

    uart_frame_timer #(
        .LIMIT (TimeoutLimit)
    ) u_timer (
        .i_SysClock (i_SysClock),
        .i_Reset    (i_Reset),
        .i_Clear    (bus.i_ByteValid),
        .i_Enable   (timerEn),
        .o_Expire   (expire)
    );

    always_comb begin
        stateD    = stateQ;
        lenD      = lenQ;
        chkD      = chkQ;
        cntD      = cntQ;
        payByteD  = payByteQ;
        payValidD = 1'b0;
        payLastD  = 1'b0;
        okD       = 1'b0;
        errD      = 1'b0;
        errCodeD  = errCodeQ;

        unique case (stateQ)
            ST_IDLE: begin
                if (bus.i_ByteValid && (bus.i_Byte == SOF_BYTE)) begin
                    stateD = ST_LEN;
                end
            end
            ST_LEN: begin
                if (bus.i_ByteValid) begin
                    lenD = bus.i_Byte;
                    chkD = bus.i_Byte;
                    cntD = '0;
                    if (bus.i_Byte > MaxLen8) begin
                        errD     = 1'b1;
                        errCodeD = ERR_LEN;
                        stateD   = ST_IDLE;
                    end else if (bus.i_Byte == 8'd0) begin
                        stateD = ST_CHECK;
                    end else begin
                        stateD = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (bus.i_ByteValid) begin
                    payByteD  = bus.i_Byte;
                    payValidD = 1'b1;
                    chkD      = chkQ ^ bus.i_Byte;
                    cntD      = cntQ + 8'd1;
                    if ((cntQ + 8'd1) == lenQ) begin
                        payLastD = 1'b1;
                        stateD   = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (bus.i_ByteValid) begin
                    if (bus.i_Byte == chkQ) begin
                        okD = 1'b1;
                    end else begin
                        errD     = 1'b1;
                        errCodeD = ERR_CHK;
                    end
                    stateD = ST_IDLE;
                end
            end
            default: stateD = ST_IDLE;
        endcase

        // A strobe landing on the expiry cycle takes priority over the timeout.
        if (expire && !bus.i_ByteValid) begin
            errD     = 1'b1;
            errCodeD = ERR_TIMEOUT;
            stateD   = ST_IDLE;
        end
    end

    always_ff @(posedge i_SysClock) begin
        if (i_Reset) begin
            stateQ    <= ST_IDLE;
            lenQ      <= '0;
            chkQ      <= '0;
            cntQ      <= '0;
            payByteQ  <= '0;
            payValidQ <= 1'b0;
            payLastQ  <= 1'b0;
            okQ       <= 1'b0;
            errQ      <= 1'b0;
            errCodeQ  <= ERR_NONE;
        end else begin
            stateQ    <= stateD;
            lenQ      <= lenD;
            chkQ      <= chkD;
            cntQ      <= cntD;
            payByteQ  <= payByteD;
            payValidQ <= payValidD;
            payLastQ  <= payLastD;
            okQ       <= okD;
            errQ      <= errD;
            errCodeQ  <= errCodeD;
        end
    end

    assign bus.o_PayloadByte  = payByteQ;
    assign bus.o_PayloadValid = payValidQ;
    assign bus.o_PayloadLast  = payLastQ;
    assign bus.o_FrameOk      = okQ;
    assign bus.o_FrameErr     = errQ;
    assign bus.o_ErrCode      = errCodeQ;
    assign bus.o_Busy         = (stateQ != ST_IDLE);

endmodule
